// File: rtl/ov5640_init_seq.sv
// ov5640_init_seq: walks the OV5640 register table and feeds it to the
// SCCB/i2c write engine one 24-bit {reg_addr, reg_data} word at a time.
//
// Ports:
//   meg25      25 MHz system clock
//   rst        asynchronous active-high reset
//   start      rising edge (re)starts the sequence when not busy
//   done       i2c engine transfer-finished flag
//   ack        i2c engine ack result, valid when done first rises
//   send_dat   word presented to the i2c engine
//   sendit     transfer request level to the i2c engine
//   index      current table index
//   busy       sequence in progress
//   init_done  table completed
//   init_err   table aborted after exhausting retries
module ov5640_init_seq #(
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned POWERUP_DELAY = 500000,
    parameter int unsigned GAP_CYCLES    = 250,
    parameter int unsigned DELAY_UNIT    = 25000,
    parameter int unsigned RETRY_MAX     = 3,
    parameter int unsigned WATCHDOG      = 100000
) (
    input  logic        meg25,
    input  logic        rst,
    input  logic        start,
    input  logic        done,
    input  logic        ack,
    output logic [23:0] send_dat,
    output logic        sendit,
    output logic [7:0]  index,
    output logic        busy,
    output logic        init_done,
    output logic        init_err
);

    // One shared cycle counter covers power-up, gap and watchdog waits,
    // so it is sized for the largest of the three.
    localparam int unsigned MAX_A =
        (POWERUP_DELAY > GAP_CYCLES) ? POWERUP_DELAY : GAP_CYCLES;
    localparam int unsigned CNT_MAX =
        (MAX_A > WATCHDOG) ? MAX_A : WATCHDOG;
    localparam int CW =
        (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int RW =
        (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_FETCH,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_TDELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   dly_q;
    logic [RW-1:0] retry_q;
    logic          redo_q;
    logic          ack_q;
    logic [1:0]    start_q;
    logic [23:0]   send_dat_q;
    logic          sendit_q;
    logic [7:0]    index_q;
    logic          busy_q;
    logic          init_done_q;
    logic          init_err_q;

    logic [23:0]   rom_w;
    logic [31:0]   cnt_ext;
    logic          start_edge;
    logic          is_delay;

    assign cnt_ext    = 32'(cnt_q);
    assign start_edge = start_q[0] & ~start_q[1];
    assign is_delay   = (rom_w[23:8] == 16'hFFFF);

    // Register table; an address of FFFF marks a delay entry whose
    // data field counts DELAY_UNIT ticks.
    always_comb begin
        rom_w = 24'h000000;
        unique case (index_q)
            8'd0:    rom_w = 24'h310311;
            8'd1:    rom_w = 24'h300882;
            8'd2:    rom_w = 24'hFFFF05;
            8'd3:    rom_w = 24'h300842;
            8'd4:    rom_w = 24'h310303;
            8'd5:    rom_w = 24'h3017FF;
            8'd6:    rom_w = 24'h3018FF;
            8'd7:    rom_w = 24'h303421;
            default: rom_w = 24'h000000;
        endcase
    end

    always_ff @(posedge meg25 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dly_q       <= '0;
            retry_q     <= '0;
            redo_q      <= 1'b0;
            ack_q       <= 1'b0;
            start_q     <= 2'b00;
            send_dat_q  <= '0;
            sendit_q    <= 1'b0;
            index_q     <= '0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
        end else begin
            start_q <= {start_q[0], start};
            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_edge) begin
                        index_q     <= '0;
                        retry_q     <= '0;
                        redo_q      <= 1'b0;
                        init_done_q <= 1'b0;
                        init_err_q  <= 1'b0;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_PWR_WAIT;
                    end
                end
                S_PWR_WAIT: begin
                    if (cnt_ext + 32'd1 >= POWERUP_DELAY) begin
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FETCH: begin
                    if (is_delay) begin
                        dly_q <= 32'(rom_w[7:0]) * 32'(DELAY_UNIT);
                        if (rom_w[7:0] == 8'd0) begin
                            state_q <= S_NEXT;
                        end else begin
                            state_q <= S_TDELAY;
                        end
                    end else begin
                        send_dat_q <= rom_w;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    // never raise a request over a stale done
                    if (!done) begin
                        sendit_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (done) begin
                        ack_q    <= ack;
                        sendit_q <= 1'b0;
                        state_q  <= S_WAIT_LO;
                    end else if (cnt_ext + 32'd1 >= WATCHDOG) begin
                        // watchdog expiry is handled like a NACK
                        ack_q    <= 1'b0;
                        sendit_q <= 1'b0;
                        state_q  <= S_WAIT_LO;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!done) begin
                        cnt_q <= '0;
                        if (ack_q) begin
                            retry_q <= '0;
                            redo_q  <= 1'b0;
                            state_q <= S_GAP;
                        end else if (32'(retry_q) < RETRY_MAX) begin
                            retry_q <= retry_q + RW'(1);
                            redo_q  <= 1'b1;
                            state_q <= S_GAP;
                        end else begin
                            init_err_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_ERROR;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_ext + 32'd1 >= GAP_CYCLES) begin
                        cnt_q <= '0;
                        // a retry re-fetches the same index
                        if (redo_q) begin
                            state_q <= S_FETCH;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_TDELAY: begin
                    if (dly_q <= 32'd1) begin
                        state_q <= S_NEXT;
                    end else begin
                        dly_q <= dly_q - 32'd1;
                    end
                end
                S_NEXT: begin
                    if (index_q == 8'(NUM_REGS - 1)) begin
                        init_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        index_q <= index_q + 8'd1;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    sendit_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign send_dat  = send_dat_q;
    assign sendit    = sendit_q;
    assign index     = index_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign init_err  = init_err_q;

endmodule

// File: doc/ov5640_init_seq.md
Name: ov5640_init_seq

Overview:
- Register-table sequencer that brings up the OV5640 camera over SCCB.
- Sits directly upstream of the i2c write engine: presents one 24-bit word {reg_addr[15:0], reg_data[7:0]} on send_dat, raises sendit, and waits for done.
- Also handles power-up wait, table-embedded delays, NACK retry and watchdog. Reports init_done / init_err to the VGA/camera top level.

Parameters:
- NUM_REGS, 8, number of table entries (1..256).
- POWERUP_DELAY, 500000, meg25 cycles waited after start before first entry (20 ms at 25 MHz).
- GAP_CYCLES, 250, idle cycles between a completed write and the next fetch.
- DELAY_UNIT, 25000, cycles per unit of a delay entry (1 ms).
- RETRY_MAX, 3, re-sends of one entry after NACK/timeout before error.
- WATCHDOG, 100000, max cycles from sendit high to done high.

Ports:
- meg25  in  1  system clock, 25 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  rising edge (internally registered) begins or restarts the sequence from IDLE, DONE or ERROR; ignored while busy.
- done  in  1  from i2c: high when the current transfer has finished; low again after sendit drops.
- ack  in  1  from i2c, sampled on the cycle done is first seen high: 1 = all bytes acknowledged, 0 = NACK.
- send_dat  out  24  word to i2c; stable whenever sendit is high.
- sendit  out  1  transfer request level to i2c.
- index  out  8  current table index.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- init_done  out  1  sequence completed.
- init_err  out  1  sequence aborted.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-transfer drops sendit immediately; the i2c engine is expected to abort on its own.
- Table: combinational case ROM indexed by index. Entries beyond NUM_REGS-1 are never read.
  - Fixed contents: 0: 24'h310311; 1: 24'h300882 (soft reset); 2: 24'hFFFF05 (delay); 3: 24'h300842; 4: 24'h310303; 5: 24'h3017FF; 6: 24'h3018FF; 7: 24'h303421.
- Delay entry: addr field == 16'hFFFF. It waits data*DELAY_UNIT cycles with no i2c traffic. A data value of 0 gives 0 wait cycles and goes straight to NEXT.
- States:
  - IDLE: on start edge, clear index, retry count, init_done and init_err; go to PWR_WAIT.
  - PWR_WAIT: count POWERUP_DELAY cycles, then go to FETCH.
  - FETCH: one cycle.
    - Delay entry: load counter, go to TDELAY.
    - Otherwise: load send_dat, go to SEND.
  - SEND: sendit=1, start watchdog, go to WAIT_HI.
  - WAIT_HI: hold sendit=1 and send_dat until done=1; capture ack; drop sendit next cycle; go to WAIT_LO. If the watchdog expires first, drop sendit and treat as NACK.
  - WAIT_LO: wait for done=0.
    - ack=1: clear retry count, go to GAP.
    - ack=0 or timeout: if retry count < RETRY_MAX, increment it and go to GAP, then re-send the same index; else go to ERROR.
  - GAP: GAP_CYCLES idle cycles, then go to NEXT (or back to FETCH at the same index on retry).
  - TDELAY: count down, then go to NEXT.
  - NEXT: if index == NUM_REGS-1, go to DONE; else index+1, go to FETCH.
  - DONE: init_done=1, held until the next start edge.
  - ERROR: init_err=1, index frozen at the failing entry, held until start or rst.
- Handshake invariant: sendit never rises while done=1. send_dat never changes while sendit=1.
- Latency: start edge to first sendit = POWERUP_DELAY+3 cycles.
- A start edge while busy is ignored. A start edge coinciding with rst is lost; rst wins.
- Counter widths are sized by clog2 of the largest parameter value. A delay counter of 8 bits × DELAY_UNIT must not overflow (use 32 bits).

Test Plan:
Bench parameters: POWERUP_DELAY=10, GAP_CYCLES=4, DELAY_UNIT=8, WATCHDOG=50; i2c model raises done 20 cycles after sendit with ack=1.
1. Nominal: pulse start → 7 sendit transfers carrying 310311, 300882, 300842, 310303, 3017FF, 3018FF, 303421 in order.
   - Exactly 40 idle cycles (5*8) between the end of write 1's GAP and the fetch of entry 3.
   - init_done=1, busy=0, init_err=0.
2. Single NACK: model returns ack=0 once on index 4 → 310303 sent twice; sequence completes with init_done=1.
3. Persistent NACK on index 5 → 3017FF sent 4 times; init_err=1, index=5, sendit=0, no further writes.
4. Watchdog: model never raises done on index 0 → sendit drops 50 cycles after rising; 4 attempts total, then init_err=1.
5. Reset mid-transfer: assert rst while sendit=1 on index 3 → same cycle sendit=0, index=0, busy=0. A new start replays from 310311.
6. Restart and ignore: start pulse during PWR_WAIT is ignored. A start pulse in DONE clears init_done and re-runs the full 7-write sequence.
